// File: rtl/router_sync_np_if.sv
// router_sync_np_if
//  Bundles the handshake and status signals between the router FSM, the
//  output FIFOs, the downstream read side and the router_sync_np block.
//  master : the environment (FSM / FIFOs / readers) driving the synchroniser
//  slave  : the synchroniser itself
//  Signals:
//   detect_add     header-cycle strobe; load datain as destination
//   datain         destination address field of the header byte
//   write_enb_reg  FSM request to write the current byte
//   read_enb       per-port read enable from downstream
//   empty, full    per-port FIFO status
//   clr_status     clears all timeout_sticky bits
//   vld_out        per-port data valid (~empty)
//   write_enb      one-hot FIFO write enable
//   fifo_full      full flag of the selected FIFO
//   soft_reset     per-port one-cycle FIFO soft reset
//   addr_err       last latched address was out of range
//   timeout_sticky per-port sticky record of a watchdog timeout
interface router_sync_np_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2
);
    logic                 detect_add;
    logic [ADDR_W-1:0]    datain;
    logic                 write_enb_reg;
    logic [NUM_PORTS-1:0] read_enb;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] full;
    logic                 clr_status;
    logic [NUM_PORTS-1:0] vld_out;
    logic [NUM_PORTS-1:0] write_enb;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 addr_err;
    logic [NUM_PORTS-1:0] timeout_sticky;

    modport master (
        output detect_add, datain, write_enb_reg, read_enb, empty, full, clr_status,
        input  vld_out, write_enb, fifo_full, soft_reset, addr_err, timeout_sticky
    );

    modport slave (
        input  detect_add, datain, write_enb_reg, read_enb, empty, full, clr_status,
        output vld_out, write_enb, fifo_full, soft_reset, addr_err, timeout_sticky
    );
endinterface

// File: rtl/router_sync_np.sv
// router_sync_np
//  Synchroniser between the router FSM, NUM_PORTS output FIFOs and the read
//  side. Latches the destination from the header, steers write enable and
//  full status to/from the selected FIFO, flags out-of-range destinations,
//  and runs an independent read-timeout watchdog per port that issues a
//  single-cycle soft reset and records it in a sticky status bit.
//  Ports:
//   clk     rising-edge clock
//   resetn  synchronous active-low reset
//   bus     router_sync_np_if slave modport (see interface header)
module router_sync_np #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int TIMEOUT   = 30
) (
    input  logic              clk,
    input  logic              resetn,
    router_sync_np_if.slave   bus
);
    localparam int                CNT_W      = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    // One extra bit so NUM_PORTS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);

    logic [ADDR_W-1:0]    dest_r;
    logic                 dest_ok_r;
    logic                 addr_err_r;
    logic [CNT_W-1:0]     cnt_r [NUM_PORTS];
    logic [NUM_PORTS-1:0] soft_reset_r;
    logic [NUM_PORTS-1:0] sticky_r;

    logic                 in_range_s;
    logic [NUM_PORTS-1:0] stall_s;
    logic [NUM_PORTS-1:0] hit_s;
    logic [NUM_PORTS-1:0] write_enb_s;
    logic                 fifo_full_s;

    assign in_range_s = ({1'b0, bus.datain} < PORT_LIMIT);
    // A port is stalled while it holds data that nobody is reading.
    assign stall_s    = ~bus.empty & ~bus.read_enb;

    // Destination latch: loaded on the header strobe, held otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dest_r     <= '0;
            dest_ok_r  <= 1'b1;
            addr_err_r <= 1'b0;
        end else if (bus.detect_add) begin
            dest_r     <= bus.datain;
            dest_ok_r  <= in_range_s;
            addr_err_r <= ~in_range_s;
        end else begin
            dest_r     <= dest_r;
            dest_ok_r  <= dest_ok_r;
            addr_err_r <= addr_err_r;
        end
    end

    // Steer write enable to, and full flag from, the latched destination.
    // An invalid destination selects nothing, so no FIFO is written.
    always_comb begin
        write_enb_s = '0;
        fifo_full_s = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (dest_ok_r && (dest_r == ADDR_W'(i))) begin
                write_enb_s[i] = bus.write_enb_reg;
                fifo_full_s    = bus.full[i];
            end else begin
                write_enb_s[i] = 1'b0;
            end
        end
    end

    // Timeout detect: the stall cycle in which the counter already sits at its last value.
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (stall_s[i] && (cnt_r[i] == CNT_LAST)) begin
                hit_s[i] = 1'b1;
            end else begin
                hit_s[i] = 1'b0;
            end
        end
    end

    // Per-port stall counters; a read, a timeout or reset restarts from zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!resetn) begin
                cnt_r[i] <= '0;
            end else if (!stall_s[i] || hit_s[i]) begin
                cnt_r[i] <= '0;
            end else begin
                cnt_r[i] <= cnt_r[i] + CNT_W'(1);
            end
        end
    end

    // Soft-reset pulse and sticky status; a new timeout beats a coincident clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            soft_reset_r <= '0;
            sticky_r     <= '0;
        end else begin
            soft_reset_r <= hit_s;
            sticky_r     <= hit_s | (sticky_r & ~{NUM_PORTS{bus.clr_status}});
        end
    end

    assign bus.vld_out        = ~bus.empty;
    assign bus.write_enb      = write_enb_s;
    assign bus.fifo_full      = fifo_full_s;
    assign bus.soft_reset     = soft_reset_r;
    assign bus.addr_err       = addr_err_r;
    assign bus.timeout_sticky = sticky_r;
endmodule

// File: tb/tb_router_sync_np.sv
// tb_router_sync_np
//  Directed-vector bench for router_sync_np (NUM_PORTS=3, ADDR_W=2,
//  TIMEOUT=30). Stimulus applies inputs just after each rising edge and
//  queues the hand-computed expected outputs for that cycle; an independent
//  monitor pops the queue on each falling edge and compares.
module tb_router_sync_np;
    localparam int NP = 3;
    localparam int AW = 2;
    localparam int TO = 30;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    router_sync_np_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

    router_sync_np #(.NUM_PORTS(NP), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        string      name;
        logic [2:0] vld;
        logic [2:0] we;
        logic       ff;
        logic [2:0] sr;
        logic       ae;
        logic [2:0] st;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    function automatic void cmp(string n, string f, logic [2:0] act, logic [2:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s.%s actual=%b expected=%b", n, f, act, exp_v);
        end
    endfunction

    task automatic expect_out(string n, logic [2:0] vld, logic [2:0] we, logic ff,
                              logic [2:0] sr, logic ae, logic [2:0] st);
        exp_t e;
        e.name = n; e.vld = vld; e.we = we; e.ff = ff;
        e.sr = sr; e.ae = ae; e.st = st;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every output against the expectation queued for this cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            cmp(cur.name, "vld_out",        bus.vld_out,                cur.vld);
            cmp(cur.name, "write_enb",      bus.write_enb,              cur.we);
            cmp(cur.name, "fifo_full",      {2'b00, bus.fifo_full},     {2'b00, cur.ff});
            cmp(cur.name, "soft_reset",     bus.soft_reset,             cur.sr);
            cmp(cur.name, "addr_err",       {2'b00, bus.addr_err},      {2'b00, cur.ae});
            cmp(cur.name, "timeout_sticky", bus.timeout_sticky,         cur.st);
        end
    end

    // Overall time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time bound exceeded");
    end

    initial begin
        bus.detect_add    = 1'b0;
        bus.datain        = 2'd0;
        bus.write_enb_reg = 1'b0;
        bus.read_enb      = 3'b000;
        bus.empty         = 3'b111;
        bus.full          = 3'b000;
        bus.clr_status    = 1'b0;
        resetn            = 1'b0;
        step();
        step();

        // Reset state: dest=0 valid, nothing pending.
        step(); bus.write_enb_reg = 1'b1; bus.full = 3'b001;
        expect_out("reset", 3'b000, 3'b001, 1'b1, 3'b000, 1'b0, 3'b000);

        // T1: latch dest=1, then write/full steering.
        step(); resetn = 1'b1; bus.write_enb_reg = 1'b0; bus.full = 3'b000;
        bus.detect_add = 1'b1; bus.datain = 2'd1;
        expect_out("t1_strobe", 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000);
        step(); bus.detect_add = 1'b0; bus.write_enb_reg = 1'b1; bus.full = 3'b010;
        expect_out("t1_we", 3'b000, 3'b010, 1'b1, 3'b000, 1'b0, 3'b000);
        step(); bus.full = 3'b101;
        expect_out("t1_full_other", 3'b000, 3'b010, 1'b0, 3'b000, 1'b0, 3'b000);

        // T5: dest 0 -> 2 with strobe and write in the same cycle.
        step(); bus.write_enb_reg = 1'b0; bus.full = 3'b000;
        bus.detect_add = 1'b1; bus.datain = 2'd0;
        expect_out("t5_pre", 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000);
        step(); bus.datain = 2'd2; bus.write_enb_reg = 1'b1;
        expect_out("t5_strobe", 3'b000, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000);
        step(); bus.detect_add = 1'b0; bus.full = 3'b100;
        expect_out("t5_next", 3'b000, 3'b100, 1'b1, 3'b000, 1'b0, 3'b000);

        // T2: out-of-range destination.
        step(); bus.detect_add = 1'b1; bus.datain = 2'd3; bus.full = 3'b111;
        expect_out("t2_strobe", 3'b000, 3'b100, 1'b1, 3'b000, 1'b0, 3'b000);
        step(); bus.detect_add = 1'b0;
        expect_out("t2_err", 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 3'b000);
        step();
        expect_out("t2_err_hold", 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 3'b000);
        step(); bus.detect_add = 1'b1; bus.datain = 2'd2;
        expect_out("t2_rec_strobe", 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 3'b000);
        step(); bus.detect_add = 1'b0; bus.write_enb_reg = 1'b0; bus.full = 3'b000;
        expect_out("t2_recovered", 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000);

        // T3: port 0 stalled from cycle 0, pulse only in cycle 30.
        for (int c = 0; c <= 35; c++) begin
            step(); bus.empty = 3'b110;
            expect_out($sformatf("t3_c%0d", c), 3'b001, 3'b000, 1'b0,
                       (c == 30) ? 3'b001 : 3'b000, 1'b0,
                       (c >= 30) ? 3'b001 : 3'b000);
        end
        step(); bus.empty = 3'b111; bus.clr_status = 1'b1;
        expect_out("t3_clr", 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b001);
        step(); bus.clr_status = 1'b0;
        expect_out("t3_cleared", 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000);

        // T4: read in cycle 20 restarts count, pulse in 51; clear at 50 loses to set.
        for (int c = 0; c <= 52; c++) begin
            step(); bus.empty = 3'b110;
            bus.read_enb   = (c == 20) ? 3'b001 : 3'b000;
            bus.clr_status = (c == 50);
            expect_out($sformatf("t4_c%0d", c), 3'b001, 3'b000, 1'b0,
                       (c == 51) ? 3'b001 : 3'b000, 1'b0,
                       (c >= 51) ? 3'b001 : 3'b000);
        end

        // T6: port-2 stall aborted by reset in cycle 15; count restarts afterwards.
        for (int c = 0; c <= 15; c++) begin
            step(); bus.empty = 3'b011; bus.read_enb = 3'b000; bus.write_enb_reg = 1'b1;
            resetn = (c == 15) ? 1'b0 : 1'b1;
            expect_out($sformatf("t6_c%0d", c), 3'b100, 3'b100, 1'b0, 3'b000, 1'b0, 3'b001);
        end
        for (int c = 16; c <= 45; c++) begin
            step(); resetn = 1'b1;
            expect_out($sformatf("t6_c%0d", c), 3'b100, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000);
        end
        step(); bus.empty = 3'b111; bus.write_enb_reg = 1'b0;
        expect_out("t6_restart", 3'b000, 3'b000, 1'b0, 3'b100, 1'b0, 3'b100);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
